// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and types for the seven-segment capture block.
//   SEG_0..SEG_F  : a..g segment patterns (bit6=a .. bit0=g, active-high)
//   GND_IDX0..3   : active-low one-hot ground codes for digits 0..3
//   state_t       : capture FSM states
//   gnd_decode()  : ground code -> {legal, idx[1:0]}
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [3:0] GND_IDX0 = 4'b1110;
    localparam logic [3:0] GND_IDX1 = 4'b1101;
    localparam logic [3:0] GND_IDX2 = 4'b1011;
    localparam logic [3:0] GND_IDX3 = 4'b0111;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    // Returns {legal, idx}; idx is 0 when the code is not a legal ground.
    function automatic logic [2:0] gnd_decode(input logic [3:0] g);
        logic [2:0] r;
        case (g)
            GND_IDX0: r = 3'b100;
            GND_IDX1: r = 3'b101;
            GND_IDX2: r = 3'b110;
            GND_IDX3: r = 3'b111;
            default:  r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational segment pattern -> hex nibble.
//   pattern : a..g, bit6=a .. bit0=g, active-high
//   hit     : 1 when pattern is one of the sixteen hex glyphs
//   nibble  : decoded value (0 when hit=0)
module seg7_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (pattern)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: monitors a 4-digit multiplexed seven-segment bus and
// reassembles the 16-bit value being displayed.
//   clk, rst    : clock, synchronous active-high reset
//   grounds_in  : active-low one-hot digit select
//   display_in  : segments a..g (bit6=a), active-high
//   data_out    : last published frame, digit0 in [15:12] .. digit3 in [3:0]
//   data_valid  : 1-cycle pulse when data_out updates
//   seg_err     : 1-cycle pulse, captured pattern is not a hex glyph
//   seq_err     : 1-cycle pulse, illegal ground code / out-of-order / missed digit
// Optional feature macro: CAPTURE_CONFIRM_EN -- publish a frame only when it
// matches the previous good frame (filters ghosting during value changes).
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  grounds_in,
    input  logic [6:0]  display_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        seg_err,
    output logic        seq_err
);

    // Capture fires on the cycle the counter steps to SETTLE_CYC-1.
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC - 1);

    logic [3:0]       gnd_r, gnd_p;
    logic [6:0]       disp_r, disp_p;
    logic [CNT_W-1:0] cnt;
    logic             done;      // current phase already captured
    state_t           state;
    logic [1:0]       exp_idx;
    logic [3:0][3:0]  slot;
    logic             bad;
`ifdef CAPTURE_CONFIRM_EN
    logic [15:0]      prev_frame;
    logic             prev_vld;
`endif

    logic       hit;
    logic [3:0] nib;

    seg7_decode u_dec (
        .pattern (disp_r),
        .hit     (hit),
        .nibble  (nib)
    );

    logic [2:0]  gdec;
    logic        g_ok;
    logic [1:0]  g_idx;
    logic        chg_g, chg_d, cap, seq_fault;
    logic [1:0]  exp_eff;
    logic [15:0] frame;
    logic [3:0]  cap_val;

    always_comb begin
        gdec     = gnd_decode(gnd_r);
        g_ok     = gdec[2];
        g_idx    = gdec[1:0];
        chg_g    = (gnd_r != gnd_p);
        chg_d    = (disp_r != disp_p);
        cap      = g_ok && !chg_g && !chg_d && !done && (cnt == CNT_CAP);
        cap_val  = hit ? nib : 4'h0;
        // PUBLISH already points at digit 0 for the next frame.
        exp_eff  = (state == PUBLISH) ? 2'd0 : exp_idx;
        // Illegal codes are faults in any state; ordering and missed digits
        // only matter once a frame is being collected.
        seq_fault = (chg_g && !g_ok) ||
                    ((state != HUNT) && chg_g && g_ok && (!done || g_idx != exp_eff));
        frame    = {slot[0], slot[1], slot[2], slot[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnd_r      <= 4'hF;
            gnd_p      <= 4'hF;
            disp_r     <= '0;
            disp_p     <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            state      <= HUNT;
            exp_idx    <= 2'd0;
            slot       <= '0;
            bad        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            seg_err    <= 1'b0;
            seq_err    <= 1'b0;
`ifdef CAPTURE_CONFIRM_EN
            prev_frame <= '0;
            prev_vld   <= 1'b0;
`endif
        end else begin
            gnd_r  <= grounds_in;
            gnd_p  <= gnd_r;
            disp_r <= display_in;
            disp_p <= disp_r;

            if (chg_g || chg_d)    cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

            if (chg_g)    done <= 1'b0;
            else if (cap) done <= 1'b1;

            data_valid <= 1'b0;
            seg_err    <= 1'b0;
            seq_err    <= 1'b0;

            case (state)
                HUNT: begin
                    if (cap && g_idx == 2'd0) begin
                        slot[0] <= cap_val;
                        seg_err <= !hit;
                        bad     <= !hit;
                        exp_idx <= 2'd1;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cap) begin
                        slot[g_idx] <= cap_val;
                        seg_err     <= !hit;
                        if (!hit) bad <= 1'b1;
                        exp_idx     <= g_idx + 2'd1;
                        if (g_idx == 2'd3) state <= PUBLISH;
                    end
                end
                PUBLISH: begin
`ifdef CAPTURE_CONFIRM_EN
                    if (!bad) begin
                        if (prev_vld && prev_frame == frame) begin
                            data_out   <= frame;
                            data_valid <= 1'b1;
                        end
                        prev_frame <= frame;
                        prev_vld   <= 1'b1;
                    end
`else
                    if (!bad) begin
                        data_out   <= frame;
                        data_valid <= 1'b1;
                    end
`endif
                    bad     <= 1'b0;
                    exp_idx <= 2'd0;
                    state   <= COLLECT;
                end
                default: state <= HUNT;
            endcase

            // Sequence faults override whatever transition was chosen above.
            if (seq_fault) begin
                seq_err <= 1'b1;
                bad     <= 1'b0;
                state   <= HUNT;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed bench for seven_seg_capture (SETTLE_CYC=16).
// Pulse outputs are counted on the falling edge; the directed sequence checks
// the running counts and data_out against hand-computed totals.
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  grounds_in = 4'hF;
    logic [6:0]  display_in = 7'h00;
    logic [15:0] data_out;
    logic        data_valid, seg_err, seq_err;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0, n_seg = 0, n_seq = 0;

    always #5 clk = ~clk;

    seven_seg_capture dut (
        .clk        (clk),
        .rst        (rst),
        .grounds_in (grounds_in),
        .display_in (display_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .seg_err    (seg_err),
        .seq_err    (seq_err)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) n_valid <= n_valid + 1;
            if (seg_err)    n_seg   <= n_seg + 1;
            if (seq_err)    n_seq   <= n_seq + 1;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [3:0] gnd_of(input int idx);
        case (idx)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are held for n edges.
    task automatic show(input int idx, input logic [6:0] pat, input int n);
        grounds_in = gnd_of(idx);
        display_in = pat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [15:0] v);
        show(0, seg_of(v[15:12]), 16);
        show(1, seg_of(v[11:8]),  16);
        show(2, seg_of(v[7:4]),   16);
        show(3, seg_of(v[3:0]),   16);
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef CAPTURE_CONFIRM_EN
    localparam int V1 = 2, V2 = 3, V4 = 4, V5 = 5, V6 = 6;
`else
    localparam int V1 = 3, V2 = 4, V4 = 5, V5 = 7, V6 = 10;
`endif

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  {16'h0, data_out},  32'h0);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_seg",   {31'h0, seg_err},    32'h0);
        chk("rst_seq",   {31'h0, seq_err},    32'h0);
        rst = 1'b0;
        hold(2);

        // Clean scan of 0x0064
        repeat (3) frame(16'h0064);
        hold(4);
        chk("scan_valid", n_valid, V1);
        chk("scan_data",  {16'h0, data_out}, 32'h0064);
        chk("scan_seg",   n_seg, 0);
        chk("scan_seq",   n_seq, 0);

        // Illegal ground code for one cycle mid-frame
        show(0, seg_of(4'h0), 16);
        show(1, seg_of(4'h0), 16);
        grounds_in = 4'b1100;
        hold(1);
        show(2, seg_of(4'h6), 16);
        show(3, seg_of(4'h4), 16);
        hold(4);
        chk("glitch_seq",   n_seq, 1);
        chk("glitch_valid", n_valid, V1);
        frame(16'h0064);
        hold(4);
        chk("glitch_recover", n_valid, V2);

        // Blank pattern on digit 2
        show(0, seg_of(4'h0), 16);
        show(1, seg_of(4'h0), 16);
        show(2, 7'b0000000,   16);
        show(3, seg_of(4'h4), 16);
        hold(4);
        chk("segerr_seg",   n_seg, 1);
        chk("segerr_valid", n_valid, V2);
        chk("segerr_data",  {16'h0, data_out}, 32'h0064);

        // Digit 1 held too briefly
        show(0, seg_of(4'h0), 16);
        show(1, seg_of(4'h0), 14);
        show(2, seg_of(4'h6), 16);
        show(3, seg_of(4'h4), 16);
        hold(4);
        chk("missed_seq",   n_seq, 2);
        chk("missed_valid", n_valid, V2);
        frame(16'h0064);
        hold(4);
        chk("missed_recover", n_valid, V4);

        // Reset after digit 1 captured
        show(0, seg_of(4'hA), 16);
        show(1, seg_of(4'hB), 18);
        rst = 1'b1;
        hold(2);
        chk("midrst_data",  {16'h0, data_out},  32'h0);
        chk("midrst_valid", {31'h0, data_valid}, 32'h0);
        rst = 1'b0;
        frame(16'hABCD);
        frame(16'hABCD);
        hold(4);
        chk("midrst_pub_valid", n_valid, V5);
        chk("midrst_pub_data",  {16'h0, data_out}, 32'hABCD);

        // Changing value: 0x1234, 0x1235, 0x1235
        frame(16'h1234);
        frame(16'h1235);
        frame(16'h1235);
        hold(4);
        chk("confirm_valid", n_valid, V6);
        chk("confirm_data",  {16'h0, data_out}, 32'h1235);
        chk("final_seg",     n_seg, 1);
        chk("final_seq",     n_seq, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
